alu_issue_ctrl: RTL and testbench

Synthesizable sequencer that drives the datapath ALU from the issuing side. It accepts one operation request at a time over a valid/ready handshake. It decodes the opcode onto alu_control_out, drives Op1/Op2/immd, waits a fixed settle time, then captures Result, R0, Pos and Neg into a held response. It sits between instruction decode and the ALU, and replaces ad-hoc direct stimulus of the ALU.

---
 rtl/alu_issue_ctrl.sv | 129 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue-side sequencer for the datapath ALU: accepts one request, drives the ALU,
// waits a fixed settle time, then holds the captured result until it is consumed.
module alu_issue_ctrl #(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_opcode,
   input  logic [15:0]      req_op1,
   input  logic [15:0]      req_op2,
   input  logic [15:0]      req_immd,
   output logic [2:0]       alu_control_out,
   output logic [15:0]      Op1,
   output logic [15:0]      Op2,
   output logic [15:0]      immd,
   input  logic [15:0]      alu_result,
   input  logic [15:0]      alu_r0,
   input  logic             alu_pos,
   input  logic             alu_neg,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [15:0]      rsp_result,
   output logic [15:0]      rsp_r0,
   output logic             rsp_pos,
   output logic             rsp_neg,
   output logic             rsp_err,
   output logic [CNT_W-1:0] op_count
);

   localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [SC_W-1:0] settle_cnt;
   logic            accept;
   logic            capture;

   assign accept  = req_valid && (state == IDLE);
   assign capture = (state == SETTLE) && (settle_cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               state_next = req_opcode[3] ? RESP : SETTLE;
            end
         end
         SETTLE: begin
            if (settle_cnt == '0) begin
               state_next = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == IDLE);
      rsp_valid = (state == RESP);
   end

   // ALU drive registers only change on a legal accept so the ALU stays stable afterwards
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_control_out <= '0;
         Op1             <= '0;
         Op2             <= '0;
         immd            <= '0;
         settle_cnt      <= '0;
      end else if (accept && !req_opcode[3]) begin
         alu_control_out <= req_opcode[2:0];
         Op1             <= req_op1;
         Op2             <= req_op2;
         immd            <= req_immd;
         settle_cnt      <= SETTLE_LOAD;
      end else if ((state == SETTLE) && (settle_cnt != '0)) begin
         settle_cnt <= settle_cnt - SC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_result <= '0;
         rsp_r0     <= '0;
         rsp_pos    <= 1'b0;
         rsp_neg    <= 1'b0;
         rsp_err    <= 1'b0;
         op_count   <= '0;
      end else if (accept && req_opcode[3]) begin
         rsp_result <= '0;
         rsp_r0     <= '0;
         rsp_pos    <= 1'b0;
         rsp_neg    <= 1'b0;
         rsp_err    <= 1'b1;
      end else if (capture) begin
         rsp_result <= alu_result;
         rsp_r0     <= alu_r0;
         rsp_pos    <= alu_pos;
         rsp_neg    <= alu_neg;
         rsp_err    <= 1'b0;
         op_count   <= op_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a short-settle instance with a 4-bit counter
// and a long-settle instance used for the reset-abort sequence.
module tb_alu_issue_ctrl;

   localparam int SA = 1;
   localparam int SB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]  req_opcode = '0;
   logic [15:0] req_op1 = '0, req_op2 = '0, req_immd = '0;
   logic [15:0] alu_result = '0, alu_r0 = '0;
   logic        alu_pos = 1'b0, alu_neg = 1'b0;

   logic        rst_n_a = 1'b0, req_valid_a = 1'b0, rsp_ready_a = 1'b0;
   logic        req_ready_a, rsp_valid_a, rsp_pos_a, rsp_neg_a, rsp_err_a;
   logic [2:0]  ctrl_a;
   logic [15:0] op1_a, op2_a, immd_a, rsp_result_a, rsp_r0_a;
   logic [3:0]  op_count_a;

   logic        rst_n_b = 1'b0, req_valid_b = 1'b0, rsp_ready_b = 1'b0;
   logic        req_ready_b, rsp_valid_b, rsp_pos_b, rsp_neg_b, rsp_err_b;
   logic [2:0]  ctrl_b;
   logic [15:0] op1_b, op2_b, immd_b, rsp_result_b, rsp_r0_b;
   logic [15:0] op_count_b;

   alu_issue_ctrl #(.SETTLE_CYCLES(SA), .CNT_W(4)) dut_a (
      .clk(clk), .rst_n(rst_n_a),
      .req_valid(req_valid_a), .req_ready(req_ready_a), .req_opcode(req_opcode),
      .req_op1(req_op1), .req_op2(req_op2), .req_immd(req_immd),
      .alu_control_out(ctrl_a), .Op1(op1_a), .Op2(op2_a), .immd(immd_a),
      .alu_result(alu_result), .alu_r0(alu_r0), .alu_pos(alu_pos), .alu_neg(alu_neg),
      .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_result(rsp_result_a),
      .rsp_r0(rsp_r0_a), .rsp_pos(rsp_pos_a), .rsp_neg(rsp_neg_a), .rsp_err(rsp_err_a),
      .op_count(op_count_a)
   );

   alu_issue_ctrl #(.SETTLE_CYCLES(SB), .CNT_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n_b),
      .req_valid(req_valid_b), .req_ready(req_ready_b), .req_opcode(req_opcode),
      .req_op1(req_op1), .req_op2(req_op2), .req_immd(req_immd),
      .alu_control_out(ctrl_b), .Op1(op1_b), .Op2(op2_b), .immd(immd_b),
      .alu_result(alu_result), .alu_r0(alu_r0), .alu_pos(alu_pos), .alu_neg(alu_neg),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_result(rsp_result_b),
      .rsp_r0(rsp_r0_b), .rsp_pos(rsp_pos_b), .rsp_neg(rsp_neg_b), .rsp_err(rsp_err_b),
      .op_count(op_count_b)
   );

   typedef struct {
      logic [3:0]  opcode;
      logic [15:0] op1;
      logic [15:0] op2;
      logic [15:0] immd;
      logic [15:0] a_res;
      logic [15:0] a_r0;
      logic        a_pos;
      logic        a_neg;
      logic [2:0]  exp_ctrl;
      logic [15:0] exp_op1;
      logic [15:0] exp_res;
      logic [15:0] exp_r0;
      logic        exp_pos;
      logic        exp_neg;
      logic        exp_err;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   logic [3:0]  exp_cnt_a = '0;
   logic [15:0] exp_cnt_b = '0;
   logic [15:0] exp_op2_a = '0, exp_immd_a = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      req_opcode = v.opcode;
      req_op1    = v.op1;
      req_op2    = v.op2;
      req_immd   = v.immd;
      alu_result = v.a_res;
      alu_r0     = v.a_r0;
      alu_pos    = v.a_pos;
      alu_neg    = v.a_neg;
   endtask

   task automatic run_a(input vec_t v);
      int   cyc;
      logic legal;
      legal = !v.opcode[3];
      @(negedge clk);
      chk("a_ready_idle", 32'(req_ready_a), 32'(1));
      drive(v);
      req_valid_a = 1'b1;
      @(negedge clk);
      req_valid_a = 1'b0;
      if (legal) begin
         exp_op2_a  = v.op2;
         exp_immd_a = v.immd;
         exp_cnt_a  = exp_cnt_a + 4'd1;
      end
      chk("a_ctrl", 32'(ctrl_a), 32'(v.exp_ctrl));
      chk("a_op1", 32'(op1_a), 32'(v.exp_op1));
      chk("a_op2", 32'(op2_a), 32'(exp_op2_a));
      chk("a_immd", 32'(immd_a), 32'(exp_immd_a));
      chk("a_ready_busy", 32'(req_ready_a), 32'(0));
      cyc = 0;
      while (!rsp_valid_a && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("a_latency", 32'(cyc), legal ? 32'(SA) : 32'(0));
      chk("a_result", 32'(rsp_result_a), 32'(v.exp_res));
      chk("a_r0", 32'(rsp_r0_a), 32'(v.exp_r0));
      chk("a_pos", 32'(rsp_pos_a), 32'(v.exp_pos));
      chk("a_neg", 32'(rsp_neg_a), 32'(v.exp_neg));
      chk("a_err", 32'(rsp_err_a), 32'(v.exp_err));
      chk("a_count", 32'(op_count_a), 32'(exp_cnt_a));
      $display("txn A op=%h op1=%h res=%h err=%b cnt=%0d lat=%0d", v.opcode, v.op1,
               rsp_result_a, rsp_err_a, op_count_a, cyc);
      rsp_ready_a = 1'b1;
      @(negedge clk);
      rsp_ready_a = 1'b0;
      chk("a_rsp_dropped", 32'(rsp_valid_a), 32'(0));
      chk("a_ready_back", 32'(req_ready_a), 32'(1));
   endtask

   task automatic run_b(input vec_t v);
      int cyc;
      @(negedge clk);
      chk("b_ready_idle", 32'(req_ready_b), 32'(1));
      drive(v);
      req_valid_b = 1'b1;
      @(negedge clk);
      req_valid_b = 1'b0;
      exp_cnt_b = exp_cnt_b + 16'd1;
      chk("b_ctrl", 32'(ctrl_b), 32'(v.exp_ctrl));
      chk("b_op1", 32'(op1_b), 32'(v.exp_op1));
      cyc = 0;
      while (!rsp_valid_b && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("b_latency", 32'(cyc), 32'(SB));
      chk("b_result", 32'(rsp_result_b), 32'(v.exp_res));
      chk("b_err", 32'(rsp_err_b), 32'(v.exp_err));
      chk("b_count", 32'(op_count_b), 32'(exp_cnt_b));
      $display("txn B op=%h op1=%h res=%h cnt=%0d lat=%0d", v.opcode, v.op1,
               rsp_result_b, op_count_b, cyc);
      rsp_ready_b = 1'b1;
      @(negedge clk);
      rsp_ready_b = 1'b0;
      chk("b_ready_back", 32'(req_ready_b), 32'(1));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[6];
      vec_t v;
      int   cyc;
      logic [15:0] held_res;

      tbl[0] = '{4'h1, 16'h0001, 16'h0001, 16'h0002, 16'h0002, 16'h0000, 1'b1, 1'b0,
                 3'd1, 16'h0001, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{4'h0, 16'h1234, 16'h4321, 16'h0000, 16'h5555, 16'h00AA, 1'b1, 1'b0,
                 3'd0, 16'h1234, 16'h5555, 16'h00AA, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{4'h7, 16'hFFFF, 16'h0001, 16'h00FF, 16'h8000, 16'hFFFF, 1'b0, 1'b1,
                 3'd7, 16'hFFFF, 16'h8000, 16'hFFFF, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{4'h9, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h7777, 16'h6666, 1'b1, 1'b1,
                 3'd7, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{4'h3, 16'h0F0F, 16'hF0F0, 16'h1234, 16'h0000, 16'h0F0F, 1'b0, 1'b0,
                 3'd3, 16'h0F0F, 16'h0000, 16'h0F0F, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{4'hF, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 1'b1, 1'b0,
                 3'd3, 16'h0F0F, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};

      // Reset values while both instances are held in reset
      #12;
      chk("rst_ctrl", 32'(ctrl_a), 32'(0));
      chk("rst_op1", 32'(op1_a), 32'(0));
      chk("rst_op2", 32'(op2_a), 32'(0));
      chk("rst_immd", 32'(immd_a), 32'(0));
      chk("rst_rsp_valid", 32'(rsp_valid_a), 32'(0));
      chk("rst_count", 32'(op_count_a), 32'(0));
      chk("rst_ready", 32'(req_ready_a), 32'(1));
      chk("rst_ready_b", 32'(req_ready_b), 32'(1));
      @(negedge clk);
      rst_n_a = 1'b1;
      rst_n_b = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run_a(tbl[i]);
      end

      // Backpressure: response held while a second request waits
      v = '{4'h6, 16'hFFF0, 16'h0BCD, 16'h0000, 16'h1357, 16'h0000, 1'b0, 1'b1,
            3'd6, 16'hFFF0, 16'h1357, 16'h0000, 1'b0, 1'b1, 1'b0};
      @(negedge clk);
      drive(v);
      req_valid_a = 1'b1;
      @(negedge clk);
      req_opcode = 4'h2;
      req_op1    = 16'h0042;
      req_op2    = 16'h0043;
      req_immd   = 16'h0044;
      cyc = 0;
      while (!rsp_valid_a && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("bp_latency", 32'(cyc), 32'(SA));
      alu_result = 16'h0BAD;
      alu_neg    = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_result", 32'(rsp_result_a), 32'(16'h1357));
         chk("bp_neg", 32'(rsp_neg_a), 32'(1));
         chk("bp_valid", 32'(rsp_valid_a), 32'(1));
         chk("bp_ready", 32'(req_ready_a), 32'(0));
         chk("bp_ctrl", 32'(ctrl_a), 32'(6));
         $display("txn A hold cycle %0d res=%h ready=%b", i, rsp_result_a, req_ready_a);
      end
      rsp_ready_a = 1'b1;
      @(negedge clk);
      rsp_ready_a = 1'b0;
      chk("bp_ready_after", 32'(req_ready_a), 32'(1));
      chk("bp_ctrl_after", 32'(ctrl_a), 32'(6));
      @(negedge clk);
      req_valid_a = 1'b0;
      chk("bp_second_ctrl", 32'(ctrl_a), 32'(2));
      chk("bp_second_op1", 32'(op1_a), 32'(16'h0042));
      cyc = 0;
      while (!rsp_valid_a && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("bp_second_result", 32'(rsp_result_a), 32'(16'h0BAD));
      chk("bp_second_count", 32'(op_count_a), 32'(exp_cnt_a + 4'd2));
      $display("txn A second res=%h cnt=%0d", rsp_result_a, op_count_a);
      rsp_ready_a = 1'b1;
      @(negedge clk);
      rsp_ready_a = 1'b0;

      // Long settle instance: one normal op, then reset mid-operation
      run_b('{4'h2, 16'h0100, 16'h0200, 16'h0003, 16'h0300, 16'h0001, 1'b1, 1'b0,
              3'd2, 16'h0100, 16'h0300, 16'h0001, 1'b1, 1'b0, 1'b0});
      @(negedge clk);
      drive('{4'h5, 16'h5555, 16'h6666, 16'h7777, 16'hEEEE, 16'h0000, 1'b0, 1'b1,
              3'd5, 16'h5555, 16'hEEEE, 16'h0000, 1'b0, 1'b1, 1'b0});
      req_valid_b = 1'b1;
      @(negedge clk);
      req_valid_b = 1'b0;
      chk("abort_ctrl_before", 32'(ctrl_b), 32'(5));
      @(negedge clk);
      @(negedge clk);
      rst_n_b = 1'b0;
      #1;
      chk("abort_ctrl", 32'(ctrl_b), 32'(0));
      chk("abort_op1", 32'(op1_b), 32'(0));
      chk("abort_result", 32'(rsp_result_b), 32'(0));
      chk("abort_count", 32'(op_count_b), 32'(0));
      chk("abort_ready", 32'(req_ready_b), 32'(1));
      chk("abort_valid", 32'(rsp_valid_b), 32'(0));
      @(negedge clk);
      rst_n_b = 1'b1;
      exp_cnt_b = '0;
      cyc = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rsp_valid_b) cyc++;
      end
      chk("abort_no_rsp", 32'(cyc), 32'(0));
      run_b('{4'h4, 16'h0007, 16'h0008, 16'h0009, 16'h0070, 16'h0000, 1'b1, 1'b0,
              3'd4, 16'h0007, 16'h0070, 16'h0000, 1'b1, 1'b0, 1'b0});

      // Counter wrap on the 4-bit instance after a fresh reset
      @(negedge clk);
      rst_n_a = 1'b0;
      @(negedge clk);
      rst_n_a = 1'b1;
      exp_cnt_a  = '0;
      exp_op2_a  = '0;
      exp_immd_a = '0;
      for (int i = 0; i < 16; i++) begin
         v = '{4'(i % 8), 16'(i * 257), 16'(i + 1), 16'(i + 2), 16'(i + 100), 16'(i),
               1'(i % 2), 1'(1 - i % 2), 3'(i % 8), 16'(i * 257), 16'(i + 100), 16'(i),
               1'(i % 2), 1'(1 - i % 2), 1'b0};
         run_a(v);
         if (i == 14) chk("wrap_15", 32'(op_count_a), 32'(15));
         if (i == 15) chk("wrap_0", 32'(op_count_a), 32'(0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
